// File: rtl/sha256_pkg.sv
// Shared constants, FSM state encoding and rotate helper for the SHA-256 message schedule.
// MSG_SCHED_STALL_CNT_EN adds the stall counter width used by the optional stall_cnt port.
package sha256_pkg;

  localparam int unsigned WORD_W      = 32;
  localparam int unsigned BLOCK_WORDS = 16;
  localparam int unsigned ROUNDS      = 64;
  localparam int unsigned T_W         = $clog2(ROUNDS);

  localparam int unsigned S0_ROT_A = 7;
  localparam int unsigned S0_ROT_B = 18;
  localparam int unsigned S0_SHR   = 3;
  localparam int unsigned S1_ROT_A = 17;
  localparam int unsigned S1_ROT_B = 19;
  localparam int unsigned S1_SHR   = 10;

`ifdef MSG_SCHED_STALL_CNT_EN
  localparam int unsigned STALL_W = 16;
`endif

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    EXPAND,
    DRAIN,
    DONE
  } state_e;

  function automatic logic [WORD_W-1:0] rotr(input logic [WORD_W-1:0] x, input int unsigned n);
    return (x >> n) | (x << (WORD_W - n));
  endfunction

endpackage

// File: rtl/sha256_sigma.sv
// SHA-256 small sigma functions (s0 = sigma0, s1 = sigma1) of one word; purely combinational.
module sha256_sigma
  import sha256_pkg::*;
(
  input  logic [WORD_W-1:0] x,
  output logic [WORD_W-1:0] s0,
  output logic [WORD_W-1:0] s1
);

  assign s0 = rotr(x, S0_ROT_A) ^ rotr(x, S0_ROT_B) ^ (x >> S0_SHR);
  assign s1 = rotr(x, S1_ROT_A) ^ rotr(x, S1_ROT_B) ^ (x >> S1_SHR);

endmodule

// File: rtl/sha256_msg_sched.sv
// SHA-256 message schedule: loads 16 words, emits W[0..63] over a valid/ready handshake.
// Optional MSG_SCHED_STALL_CNT_EN adds a saturating stall_cnt output.
module sha256_msg_sched
  import sha256_pkg::*;
(
  input  logic              clock,
  input  logic              reset_n,
  input  logic              start,
  input  logic [WORD_W-1:0] msg_word,
  input  logic              msg_valid,
  output logic              msg_ready,
  output logic [WORD_W-1:0] w_out,
  output logic [T_W-1:0]    w_t,
  output logic              w_valid,
  input  logic              w_ready,
  output logic              busy,
  output logic              done
`ifdef MSG_SCHED_STALL_CNT_EN
  ,
  output logic [STALL_W-1:0] stall_cnt
`endif
);

  state_e                             state_q, state_d;
  logic [T_W-1:0]                     count_q, count_d;
  logic [BLOCK_WORDS-1:0][WORD_W-1:0] win_q, win_d;
  logic [WORD_W-1:0]                  w_out_q, w_out_d;
  logic [T_W-1:0]                     w_t_q, w_t_d;
  logic                               w_valid_q, w_valid_d;
  logic                               done_q, done_d;

  logic              slot_free;
  logic              push;
  logic [WORD_W-1:0] push_word;
  logic [WORD_W-1:0] expand_word;
  logic [WORD_W-1:0] s0_lo, s1_hi, s1_lo_unused, s0_hi_unused;

  // win_q[1] = W[t-15] feeds sigma0, win_q[14] = W[t-2] feeds sigma1
  sha256_sigma u_sigma_lo (.x(win_q[1]),  .s0(s0_lo),        .s1(s1_lo_unused));
  sha256_sigma u_sigma_hi (.x(win_q[14]), .s0(s0_hi_unused), .s1(s1_hi));

  assign expand_word = s1_hi + win_q[9] + s0_lo + win_q[0];
  assign slot_free   = !w_valid_q || w_ready;

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    win_d     = win_q;
    w_out_d   = w_out_q;
    w_t_d     = w_t_q;
    w_valid_d = w_valid_q && !w_ready;
    msg_ready = 1'b0;
    push      = 1'b0;
    push_word = msg_word;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = LOAD;
          count_d = '0;
        end
      end
      LOAD: begin
        msg_ready = slot_free;
        if (msg_valid && slot_free) begin
          push = 1'b1;
          if (count_q == T_W'(BLOCK_WORDS - 1)) state_d = EXPAND;
        end
      end
      EXPAND: begin
        if (slot_free) begin
          push      = 1'b1;
          push_word = expand_word;
          if (count_q == T_W'(ROUNDS - 1)) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (w_ready) state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // A pushed word enters the window and the output slot in the same edge
    if (push) begin
      win_d     = {push_word, win_q[BLOCK_WORDS-1:1]};
      w_out_d   = push_word;
      w_t_d     = count_q;
      w_valid_d = 1'b1;
      count_d   = count_q + T_W'(1);
    end

    done_d = (state_d == DONE);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      count_q   <= '0;
      win_q     <= '0;
      w_out_q   <= '0;
      w_t_q     <= '0;
      w_valid_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      win_q     <= win_d;
      w_out_q   <= w_out_d;
      w_t_q     <= w_t_d;
      w_valid_q <= w_valid_d;
      done_q    <= done_d;
    end
  end

  assign w_out   = w_out_q;
  assign w_t     = w_t_q;
  assign w_valid = w_valid_q;
  assign done    = done_q;
  assign busy    = (state_q != IDLE);

`ifdef MSG_SCHED_STALL_CNT_EN
  logic [STALL_W-1:0] stall_q, stall_d;

  // Stalled-output cycles per block; cleared by an accepted start, frozen in IDLE
  always_comb begin
    stall_d = stall_q;
    if (state_q == IDLE) begin
      if (start) stall_d = '0;
    end else if (w_valid_q && !w_ready && (stall_q != '1)) begin
      stall_d = stall_q + STALL_W'(1);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) stall_q <= '0;
    else          stall_q <= stall_d;
  end

  assign stall_cnt = stall_q;
`endif

endmodule
